servant_uart_wb_master: RTL and testbench

UART-controlled Wishbone initiator for debug and program loading. It receives framed read and write commands on a serial line and runs single-word Wishbone cycles on the same classic interface the CPU drives into the bus mux. Read data and write acknowledgements are returned over the serial TX line. It sits beside the CPU as a second bus initiator, so memory and peripherals can be inspected or loaded without CPU involvement.

---
 rtl/servant_uart_wb_master.sv | 158 +++++++++++++++
 tb/tb_servant_uart_wb_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_wb_master.sv
// servant_uart_wb_master: UART 8N1 command port (i_rx in, o_tx out, o_busy) driving single-word Wishbone cycles (o_wb_adr/dat/sel/we/cyc out, i_wb_rdt/ack in)
module servant_uart_wb_master #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_busy,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;
  rx_state_t rx_state;
  p_state_t p_state;
  logic rx_s1, rx_s2, rx_prev, rx_valid, rx_err, is_write;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sr;
  logic [1:0] byte_cnt, resp_left;
  logic [31:0] resp;
  logic [8:0] tx_sr;
  logic [3:0] tx_bit;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sr <= '0;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt <= '0;
        end
        RX_START: if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == LAST) begin
          rx_cnt <= '0;
          rx_sr <= {rx_s2, rx_sr[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == LAST) begin
          rx_valid <= rx_s2;
          rx_err <= !rx_s2;
          rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
      endcase
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      p_state <= P_IDLE;
      is_write <= 1'b0;
      byte_cnt <= '0;
      resp_left <= '0;
      resp <= '0;
      tx_sr <= '0;
      tx_bit <= '0;
      tx_cnt <= '0;
      o_tx <= 1'b1;
      o_busy <= 1'b0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_wb_sel <= '0;
      o_wb_we <= 1'b0;
      o_wb_cyc <= 1'b0;
    end else begin
      case (p_state)
        P_IDLE: if (rx_valid && (rx_sr == 8'h57 || rx_sr == 8'h52)) begin
          p_state <= P_ADDR;
          is_write <= rx_sr[2];
          byte_cnt <= '0;
          o_busy <= 1'b1;
        end
        P_ADDR: if (rx_err) begin
          p_state <= P_IDLE;
          o_busy <= 1'b0;
        end else if (rx_valid) begin
          o_wb_adr <= {o_wb_adr[23:0], rx_sr};
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == 2'd3 && is_write) p_state <= P_DATA;
          if (byte_cnt == 2'd3 && !is_write) begin
            p_state <= P_BUS;
            o_wb_cyc <= 1'b1;
            o_wb_sel <= 4'hF;
            o_wb_we <= 1'b0;
          end
        end
        P_DATA: if (rx_err) begin
          p_state <= P_IDLE;
          o_busy <= 1'b0;
        end else if (rx_valid) begin
          o_wb_dat <= {o_wb_dat[23:0], rx_sr};
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == 2'd3) begin
            p_state <= P_BUS;
            o_wb_cyc <= 1'b1;
            o_wb_sel <= 4'hF;
            o_wb_we <= 1'b1;
          end
        end
        P_BUS: if (i_wb_ack) begin
          p_state <= P_RESP;
          o_wb_cyc <= 1'b0;
          o_wb_sel <= '0;
          o_wb_we <= 1'b0;
          o_tx <= 1'b0;
          tx_cnt <= '0;
          tx_bit <= '0;
          tx_sr <= {1'b1, is_write ? 8'h4B : i_wb_rdt[31:24]};
          resp <= {i_wb_rdt[23:0], 8'h00};
          resp_left <= is_write ? 2'd0 : 2'd3;
        end
        P_RESP: if (tx_cnt != LAST) tx_cnt <= tx_cnt + 1'b1;
        else begin
          tx_cnt <= '0;
          if (tx_bit != 4'd9) begin
            o_tx <= tx_sr[0];
            tx_sr <= {1'b1, tx_sr[8:1]};
            tx_bit <= tx_bit + 1'b1;
          end else if (resp_left != 2'd0) begin
            o_tx <= 1'b0;
            tx_sr <= {1'b1, resp[31:24]};
            resp <= {resp[23:0], 8'h00};
            resp_left <= resp_left - 1'b1;
            tx_bit <= '0;
          end else begin
            p_state <= P_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: p_state <= P_IDLE;
      endcase
    end
endmodule

// File: tb/tb_servant_uart_wb_master.sv
// tb_servant_uart_wb_master: scoreboard bench for the UART Wishbone initiator
module tb_servant_uart_wb_master;
  localparam int CPB = 8;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic we;
    int len;
    bit stable;
    int end_at;
  } bus_t;
  logic clk = 1'b0, rst_n = 1'b1, rx = 1'b1, ack = 1'b0;
  logic tx, busy, we, cyc;
  logic [31:0] adr, dat, rdt = '0;
  logic [3:0] sel;
  int passed = 0, total = 0;
  bus_t exp_bus[$], obs_bus[$];
  logic [7:0] exp_tx[$];
  logic [8:0] obs_tx[$];
  int ack_delay = 1;
  logic [31:0] rdt_val = '0;
  int cyc_n = 0, busy_fall_at = 0;
  bit busy_seen = 0;
  always #5 clk = ~clk;
  servant_uart_wb_master #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_tx(tx), .o_busy(busy),
    .o_wb_adr(adr), .o_wb_dat(dat), .o_wb_sel(sel), .o_wb_we(we), .o_wb_cyc(cyc),
    .i_wb_rdt(rdt), .i_wb_ack(ack)
  );
  initial begin
    int d;
    d = 0;
    forever begin
      @(negedge clk);
      if (cyc && !ack) begin
        if (d == ack_delay) begin
          ack = 1'b1;
          rdt = rdt_val;
          d = 0;
        end else begin
          d++;
          rdt = 32'hBAD0_0000 | 32'(d);
        end
      end else begin
        ack = 1'b0;
        rdt = 32'hDEAD_0BAD;
        d = 0;
      end
    end
  end
  initial begin
    bus_t cur;
    bit in_cyc, prev_busy;
    in_cyc = 0;
    prev_busy = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      cyc_n++;
      if (busy) busy_seen = 1;
      if (prev_busy && !busy) busy_fall_at = cyc_n;
      prev_busy = busy;
      if (cyc) begin
        if (!in_cyc) begin
          cur.adr = adr;
          cur.dat = dat;
          cur.we = we;
          cur.len = 0;
          cur.stable = 1;
          in_cyc = 1;
        end
        cur.len++;
        if (adr !== cur.adr || dat !== cur.dat || we !== cur.we || sel !== 4'hF) cur.stable = 0;
      end else if (in_cyc) begin
        in_cyc = 0;
        cur.end_at = cyc_n;
        obs_bus.push_back(cur);
      end
    end
  end
  initial begin
    logic [7:0] b;
    logic ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        obs_tx.push_back({ok & (tx === 1'b1), b});
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    send_byte(w ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i+:8]);
    if (w) for (int i = 3; i >= 0; i--) send_byte(d[8*i+:8]);
  endtask
  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total += 7;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (cyc !== 1'b0) $display("FAIL reset_cyc got %b want 0", cyc); else passed++;
    if (we !== 1'b0) $display("FAIL reset_we got %b want 0", we); else passed++;
    if (sel !== 4'h0) $display("FAIL reset_sel got %h want 0", sel); else passed++;
    if (adr !== 32'h0) $display("FAIL reset_adr got %h want 0", adr); else passed++;
    if (dat !== 32'h0) $display("FAIL reset_dat got %h want 0", dat); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_cmd(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] r, input int dly, input int extra);
    bus_t e, o;
    int n, nb;
    logic [7:0] eb;
    ack_delay = dly;
    rdt_val = r;
    nb = w ? 1 : 4;
    exp_bus.push_back('{adr: a, dat: d, we: w, len: dly + 1, stable: 1, end_at: 0});
    if (w) exp_tx.push_back(8'h4B);
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(r[8*i+:8]);
    send_cmd(w, a, d);
    total++;
    if (busy !== 1'b1) $display("FAIL %s busy_during got %b want 1", name, busy); else passed++;
    if (extra > 0) begin
      n = 0;
      while (tx !== 1'b0 && n < 20 * CPB) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (tx !== 1'b0) $display("FAIL %s resp_start got tx=%b want 0", name, tx); else passed++;
      for (int i = 0; i < extra; i++) send_byte(i[0] ? 8'h52 : 8'h57);
    end
    n = 0;
    while (busy && n < 60 * CPB) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL %s busy_timeout got %b want 0", name, busy); else passed++;
    e = exp_bus.pop_front();
    total++;
    if (obs_bus.size() != 1) $display("FAIL %s bus_count got %0d want 1", name, obs_bus.size()); else passed++;
    if (obs_bus.size() > 0) begin
      o = obs_bus.pop_front();
      total += 5;
      if (o.adr !== e.adr) $display("FAIL %s adr got %h want %h", name, o.adr, e.adr); else passed++;
      if (o.we !== e.we) $display("FAIL %s we got %b want %b", name, o.we, e.we); else passed++;
      if (o.len != e.len) $display("FAIL %s cyc_len got %0d want %0d", name, o.len, e.len); else passed++;
      if (!o.stable) $display("FAIL %s bus_stable got 0 want 1", name); else passed++;
      if (busy_fall_at - o.end_at != 10 * CPB * nb)
        $display("FAIL %s busy_fall got %0d want %0d", name, busy_fall_at - o.end_at, 10 * CPB * nb);
      else passed++;
      if (w) begin
        total++;
        if (o.dat !== e.dat) $display("FAIL %s dat got %h want %h", name, o.dat, e.dat); else passed++;
      end
    end
    obs_bus.delete();
    while (exp_tx.size() > 0) begin
      eb = exp_tx.pop_front();
      total++;
      if (obs_tx.size() == 0) $display("FAIL %s tx_byte got none want %h", name, eb);
      else begin
        if (obs_tx[0] !== {1'b1, eb}) $display("FAIL %s tx_byte got %h want %h", name, obs_tx[0], {1'b1, eb});
        else passed++;
        void'(obs_tx.pop_front());
      end
    end
    total++;
    if (obs_tx.size() != 0) $display("FAIL %s tx_extra got %0d want 0", name, obs_tx.size()); else passed++;
    obs_tx.delete();
  endtask
  task automatic test_write;
    test_cmd("write", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1, 0);
  endtask
  task automatic test_read;
    test_cmd("read", 1'b0, 32'h4000_0000, 32'h0, 32'h0000_0001, 1, 0);
  endtask
  task automatic test_slow;
    test_cmd("slow_read", 1'b0, 32'h0000_0ABE, 32'h0, 32'h1234_5678, 7, 0);
    test_cmd("slow_write", 1'b1, 32'h8000_0003, 32'hA5C3_0F96, 32'h0, 7, 0);
  endtask
  task automatic test_errors;
    busy_seen = 0;
    send_byte(8'h00);
    send_byte(8'h57, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total += 3;
    if (obs_bus.size() != 0) $display("FAIL err_bus got %0d want 0", obs_bus.size()); else passed++;
    if (obs_tx.size() != 0) $display("FAIL err_tx got %0d want 0", obs_tx.size()); else passed++;
    if (busy_seen) $display("FAIL err_busy got 1 want 0"); else passed++;
    test_cmd("after_err", 1'b0, 32'h4000_0000, 32'h0, 32'h0000_0001, 1, 0);
  endtask
  task automatic test_reset_mid;
    int n;
    ack_delay = 100000;
    send_cmd(1'b0, 32'h0000_0010, 32'h0);
    n = 0;
    while (!cyc && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cyc !== 1'b1) $display("FAIL rst_cyc_wait got %b want 1", cyc); else passed++;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (cyc !== 1'b0) $display("FAIL rst_bus_cyc got %b want 0", cyc); else passed++;
    if (tx !== 1'b1) $display("FAIL rst_bus_tx got %b want 1", tx); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_bus_busy got %b want 0", busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    send_cmd(1'b1, 32'h0000_0020, 32'h1111_2222);
    n = 0;
    while (tx !== 1'b0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 3;
    if (cyc !== 1'b0) $display("FAIL rst_tx_cyc got %b want 0", cyc); else passed++;
    if (tx !== 1'b1) $display("FAIL rst_tx_tx got %b want 1", tx); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_tx_busy got %b want 0", busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    obs_bus.delete();
    obs_tx.delete();
    test_cmd("after_rst", 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 1, 0);
  endtask
  task automatic test_overrun;
    test_cmd("overrun", 1'b0, 32'h0000_2000, 32'h0, 32'h89AB_CDEF, 1, 3);
    test_cmd("after_overrun", 1'b0, 32'h0000_2004, 32'h0, 32'h0F1E_2D3C, 1, 0);
  endtask
  task automatic test_back_to_back;
    test_cmd("b2b_w", 1'b1, 32'h0000_3000, 32'h0102_0304, 32'h0, 1, 0);
    test_cmd("b2b_r", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_0000, 2, 0);
  endtask
  initial begin
    test_reset;
    test_write;
    test_read;
    test_slow;
    test_errors;
    test_reset_mid;
    test_overrun;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
